// File: rtl/param_gemm_cim_if.sv
// CPU-side PIM port bundle for param_gemm_cim: command/address/data in, handshake and read data out.
interface param_gemm_cim_if;
  logic        cs;
  logic        write;
  logic        cim;
  logic        partial_sum;
  logic        reset_output;
  logic        signed_mode;
  logic [3:0]  output_reg;
  logic [31:0] address;
  logic [31:0] input_data;
  logic        ready;
  logic        done;
  logic [31:0] cim_output;

  modport master (
    output cs, write, cim, partial_sum, reset_output, signed_mode, output_reg, address, input_data,
    input  ready, done, cim_output
  );

  modport slave (
    input  cs, write, cim, partial_sum, reset_output, signed_mode, output_reg, address, input_data,
    output ready, done, cim_output
  );
endinterface

// File: rtl/param_gemm_cim.sv
// Parametrised GeMM compute-in-memory macro: int8 weight columns, column-serial MAC sweep into
// per-column saturating accumulators, with ready/done handshake on the PIM port.
module param_gemm_cim #(
  parameter int unsigned NUM_COLS  = 8,
  parameter int unsigned COL_WORDS = 32,
  parameter int unsigned ACC_W     = 32
) (
  input logic             clk,
  input logic             rst_n,
  param_gemm_cim_if.slave bus
);
  localparam int unsigned CW = $clog2(NUM_COLS);
  localparam int unsigned WW = $clog2(COL_WORDS);
  localparam int unsigned EW = ACC_W + 2;
  localparam logic signed [EW-1:0] SMax = (EW'(1) << (ACC_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SMin = ~SMax;
  localparam logic signed [EW-1:0] UMax = (EW'(1) << ACC_W) - EW'(1);

  typedef enum logic [0:0] {StIdle, StMac} state_e;

  state_e            state_q;
  logic [CW-1:0]     col_q;
  logic [WW-1:0]     word_q;
  logic [31:0]       x_q;
  logic              mode_q;
  logic              ready_q;
  logic              done_q;
  logic [31:0]       out_q;
  logic [ACC_W-1:0]  acc_q [NUM_COLS];
  logic [31:0]       mem [NUM_COLS*COL_WORDS];

  logic [WW-1:0] a_word;
  logic [CW-1:0] a_col;
  logic          accept, wr_en, mac_go, clr_go, rd_go, sel_ok;
  logic [CW-1:0] sel;
  logic          unused_addr;

  assign a_word      = bus.address[2 +: WW];
  assign a_col       = bus.address[2+WW +: CW];
  assign unused_addr = ^{bus.address[31:2+WW+CW], bus.address[1:0]};

  // Priority: write > MAC > clear > read; nothing is accepted while a sweep runs.
  assign accept = bus.cs && ready_q;
  assign wr_en  = accept && bus.write;
  assign mac_go = accept && !bus.write && bus.cim && bus.partial_sum;
  assign clr_go = accept && !bus.write && bus.cim && !bus.partial_sum && bus.reset_output;
  assign rd_go  = accept && !bus.write && bus.cim && !bus.partial_sum && !bus.reset_output;
  assign sel_ok = 32'(bus.output_reg) < NUM_COLS;
  assign sel    = bus.output_reg[CW-1:0];

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.cim_output = out_q;

  // Lane products widened to 9-bit signed so both modes share one datapath.
  logic [31:0]             w_cur;
  logic signed [8:0]       wa, xa;
  logic signed [17:0]      prod;
  logic signed [19:0]      lane_sum;
  logic signed [EW-1:0]    a_ext, r_ext, hi, lo;
  logic [ACC_W-1:0]        acc_next;

  always_comb begin
    w_cur    = mem[{col_q, word_q}];
    lane_sum = '0;
    wa       = '0;
    xa       = '0;
    prod     = '0;
    for (int i = 0; i < 4; i++) begin
      wa       = mode_q ? {w_cur[8*i+7], w_cur[8*i +: 8]} : {1'b0, w_cur[8*i +: 8]};
      xa       = mode_q ? {x_q[8*i+7], x_q[8*i +: 8]} : {1'b0, x_q[8*i +: 8]};
      prod     = 18'(wa) * 18'(xa);
      lane_sum = lane_sum + 20'(prod);
    end
    a_ext = mode_q ? EW'($signed(acc_q[col_q])) : EW'(acc_q[col_q]);
    r_ext = a_ext + EW'(lane_sum);
    hi    = mode_q ? SMax : UMax;
    lo    = mode_q ? SMin : '0;
    if (r_ext > hi) begin
      acc_next = hi[ACC_W-1:0];
    end else if (r_ext < lo) begin
      acc_next = lo[ACC_W-1:0];
    end else begin
      acc_next = r_ext[ACC_W-1:0];
    end
  end

  // Weight storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{a_col, a_word}] <= bus.input_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      col_q   <= '0;
      word_q  <= '0;
      x_q     <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      out_q   <= '0;
      for (int c = 0; c < NUM_COLS; c++) acc_q[c] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mac_go) begin
            x_q     <= bus.input_data;
            word_q  <= a_word;
            mode_q  <= bus.signed_mode;
            col_q   <= '0;
            ready_q <= 1'b0;
            state_q <= StMac;
          end else if (clr_go) begin
            if (sel_ok) acc_q[sel] <= '0;
          end else if (rd_go) begin
            out_q <= sel_ok ? 32'(acc_q[sel]) : 32'd0;
          end
        end
        StMac: begin
          acc_q[col_q] <= acc_next;
          col_q        <= col_q + 1'b1;
          if (col_q == CW'(NUM_COLS - 1)) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_param_gemm_cim.sv
// Directed bench for param_gemm_cim: a 32-bit accumulator instance and an ACC_W=20 instance
// share the same stimulus so saturation can be observed alongside the wide result.
module tb_param_gemm_cim;
  localparam int NC = 8;
  localparam int CWD = 32;

  logic        clk, rst_n;
  logic        cs, write, cim, ps, ro, sm;
  logic [3:0]  oreg;
  logic [31:0] addr, din;
  int          checks = 0;
  int          errors = 0;

  param_gemm_cim_if bus ();
  param_gemm_cim_if bus_s ();

  assign bus.cs = cs;             assign bus_s.cs = cs;
  assign bus.write = write;       assign bus_s.write = write;
  assign bus.cim = cim;           assign bus_s.cim = cim;
  assign bus.partial_sum = ps;    assign bus_s.partial_sum = ps;
  assign bus.reset_output = ro;   assign bus_s.reset_output = ro;
  assign bus.signed_mode = sm;    assign bus_s.signed_mode = sm;
  assign bus.output_reg = oreg;   assign bus_s.output_reg = oreg;
  assign bus.address = addr;      assign bus_s.address = addr;
  assign bus.input_data = din;    assign bus_s.input_data = din;

  param_gemm_cim #(.NUM_COLS(NC), .COL_WORDS(CWD), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  param_gemm_cim #(.NUM_COLS(NC), .COL_WORDS(CWD), .ACC_W(20)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cs = 0; write = 0; cim = 0; ps = 0; ro = 0; sm = 0; oreg = '0; addr = '0; din = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] waddr(input int c, input int w);
    return 32'((c * CWD + w) * 4);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cs = 1; write = 1; addr = a; din = d;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] v, output logic [31:0] vs);
    cs = 1; cim = 1; oreg = r;
    @(negedge clk);
    idle();
    v  = bus.cim_output;
    vs = bus_s.cim_output;
  endtask

  task automatic clr(input logic [3:0] r);
    cs = 1; cim = 1; ro = 1; oreg = r;
    @(negedge clk);
    idle();
  endtask

  task automatic start_mac(input logic [31:0] a, input logic [31:0] x, input logic s);
    cs = 1; cim = 1; ps = 1; sm = s; addr = a; din = x;
    @(negedge clk);
    idle();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic mac(input logic [31:0] a, input logic [31:0] x, input logic s);
    int n;
    start_mac(a, x, s);
    wait_done(n);
  endtask

  initial begin
    logic [31:0] v, vs;
    int          n;
    logic        seen_done;

    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out", bus.cim_output, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < NC; c++) wr(waddr(c, 0), 32'd0);

    // Unsigned MAC on column 0 with latency measurement
    wr(waddr(0, 0), 32'h33221100);
    start_mac(32'd0, 32'h01010101, 1'b0);
    chk("t1_busy", 32'(bus.ready), 32'd0);
    wait_done(n);
    chk("t1_latency", 32'(n + 1), 32'd9);
    chk("t1_ready_on_done", 32'(bus.ready), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(bus.done), 32'd0);
    rd(4'd0, v, vs);
    chk("t1_acc0", v, 32'h00000066);

    // Signed MAC across all columns, then accumulate again
    do_reset();
    for (int c = 0; c < NC; c++) wr(waddr(c, 0), 32'hFFFFFFFF);
    mac(32'd0, 32'h02020202, 1'b1);
    for (int r = 0; r < NC; r++) begin
      rd(4'(r), v, vs);
      chk($sformatf("t2_acc%0d", r), v, 32'hFFFFFFF8);
    end
    mac(32'd0, 32'h02020202, 1'b1);
    rd(4'd0, v, vs);
    chk("t2_acc0_2nd", v, 32'hFFFFFFF0);
    rd(4'd7, v, vs);
    chk("t2_acc7_2nd", v, 32'hFFFFFFF0);

    // Unsigned saturation on the ACC_W=20 instance (4 x 0x3F804 = 0xFE010)
    do_reset();
    for (int i = 0; i < 4; i++) mac(32'd0, 32'hFFFFFFFF, 1'b0);
    rd(4'd3, v, vs);
    chk("t3_sat_4x", vs, 32'h000FE010);
    chk("t3_wide_4x", v, 32'h000FE010);
    mac(32'd0, 32'hFFFFFFFF, 1'b0);
    rd(4'd3, v, vs);
    chk("t3_sat_5x", vs, 32'h000FFFFF);
    chk("t3_wide_5x", v, 32'h0013D814);

    // Busy rules: write/read ignored during sweep, MAC on done cycle accepted
    do_reset();
    wr(waddr(0, 0), 32'h01020304);
    mac(32'd0, 32'h01010101, 1'b0);
    rd(4'd0, v, vs);
    chk("t4_acc0_first", v, 32'h0000000A);
    start_mac(32'd0, 32'h01010101, 1'b0);
    cs = 1; write = 1; addr = 32'd0; din = 32'h12345678;
    @(negedge clk);
    idle();
    cs = 1; cim = 1; oreg = 4'd0;
    @(negedge clk);
    idle();
    chk("t4_busy_ready", 32'(bus.ready), 32'd0);
    chk("t4_busy_out_hold", bus.cim_output, 32'h0000000A);
    wait_done(n);
    start_mac(32'd0, 32'h01010101, 1'b0);
    chk("t4_done_cycle_accept", 32'(bus.ready), 32'd0);
    wait_done(n);
    rd(4'd0, v, vs);
    chk("t4_acc0_mem_kept", v, 32'h0000001E);

    // Clear, out-of-range select and address aliasing
    do_reset();
    for (int c = 0; c < NC; c++) wr(waddr(c, 0), 32'h01010101);
    mac(32'd0, 32'h01010101, 1'b0);
    clr(4'd2);
    rd(4'd2, v, vs);
    chk("t5_clr_reg2", v, 32'd0);
    rd(4'd1, v, vs);
    chk("t5_reg1_kept", v, 32'd4);
    rd(4'd9, v, vs);
    chk("t5_reg9_zero", v, 32'd0);
    rd(4'd3, v, vs);
    chk("t5_reg3_kept", v, 32'd4);
    wr(32'(4 * CWD * NC), 32'h00000005);
    mac(32'd0, 32'h00000001, 1'b0);
    rd(4'd0, v, vs);
    chk("t5_alias_col0", v, 32'd9);
    rd(4'd2, v, vs);
    chk("t5_reg2_after", v, 32'd1);

    // Reset during MAC cycle 3
    do_reset();
    wr(waddr(0, 0), 32'h01010101);
    start_mac(32'd0, 32'h01010101, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_ready_in_reset", 32'(bus.ready), 32'd1);
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("t6_no_done", 32'(seen_done), 32'd0);
    for (int r = 0; r < 3; r++) begin
      rd(4'(r), v, vs);
      chk($sformatf("t6_acc%0d_zero", r), v, 32'd0);
    end
    mac(32'd0, 32'h01010101, 1'b0);
    rd(4'd0, v, vs);
    chk("t6_rerun_acc0", v, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
